// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg -- shared types and constants for the instruction-fetch stage.
//
// Contents:
//   fetch_state_t  : fetch controller states (IDLE, FETCH, HOLD, SQUASH)
//   NOP_ENCODING   : default bubble instruction loaded into IF/ID
//   PC_INC         : sequential fetch increment (one 32-bit word)
//   WORD_MASK      : clears address bits [1:0]
//   word_align()   : applies WORD_MASK to an address
// ---------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // one cycle after reset, no request
        FETCH  = 2'd1,   // request outstanding at fetch_pc
        HOLD   = 2'd2,   // data captured, waiting for the stall to clear
        SQUASH = 2'd3    // wrong-path request outstanding, result discarded
    } fetch_state_t;

    localparam logic [31:0] NOP_ENCODING = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if -- instruction-memory request/ack bus.
//
// Signals:
//   IMemReq   fetch request valid (fetch stage -> memory)
//   IMemAddr  word-aligned fetch address, stable while IMemReq=1 until ack
//   IMemAck   data valid; may assert in the same cycle as IMemReq
//   IMemData  fetched instruction, valid when IMemAck=1
//
// Modports: master (fetch stage), slave (instruction memory).
// ---------------------------------------------------------------------------
interface if_stage_if;

    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemData
    );

endinterface

// File: rtl/if_stage_ifid_pipe_reg.sv
// ---------------------------------------------------------------------------
// ifid_pipe_reg -- IF/ID pipeline register with flush / write-enable priority.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        load a bubble (wins over write_en=0)
//   write_en     0 = hold current contents
//   load_valid   1 = load_instr/load_pc is a real instruction, 0 = bubble
//   load_instr   instruction to load
//   load_pc      address of load_instr
//   instr, pc    register contents presented to decode
//   valid        register holds a real instruction
// ---------------------------------------------------------------------------
module ifid_pipe_reg
    import if_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        write_en,
    input  logic        load_valid,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            valid <= 1'b0;
        end else if (write_en) begin
            // Bubbles carry the NOP encoding and a zero PC so decode never
            // sees stale fetch data behind a cleared valid bit.
            instr <= load_valid ? load_instr : NOP_INSTR;
            pc    <= load_valid ? load_pc : '0;
            valid <= load_valid;
        end
    end

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage driving the IF/ID register.
//
// Owns the fetch PC, issues one outstanding request at a time on the imem
// bus, and applies redirects, stalls and flushes from decode/hazard logic.
//
// Ports:
//   Clock, Reset        rising-edge clock, asynchronous active-low reset
//   Branch, BranchDest  taken-branch redirect and its target
//   Jump, JumpDest      jump redirect and its target (wins over Branch)
//   PC_WriteEnable      0 = freeze fetch PC; redirects are ignored
//   IFIDWriteEnable     0 = hold IF/ID contents
//   IFIDFlush           load a bubble into IF/ID
//   imem                instruction-memory bus (master side)
//   Instruction, PC     IF/ID contents presented to decode
//   IFIDValid           IF/ID holds a real instruction
//
// Optional build macro IF_STAGE_PERF_CNT_EN adds FetchCount (acks delivered
// to IF/ID or the holding buffer) and SquashCount (acks discarded).
// ---------------------------------------------------------------------------
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Branch,
    input  logic          Jump,
    input  logic [31:0]   BranchDest,
    input  logic [31:0]   JumpDest,
    input  logic          PC_WriteEnable,
    input  logic          IFIDWriteEnable,
    input  logic          IFIDFlush,
    if_stage_if.master    imem,
    output logic [31:0]   Instruction,
    output logic [31:0]   PC,
    output logic          IFIDValid
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]   FetchCount,
    output logic [31:0]   SquashCount
`endif
);

    fetch_state_t state, state_nxt;

    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] redir_pc, redir_pc_nxt;   // target parked while squashing
    logic [31:0] hold_buf, hold_buf_nxt;   // instruction parked during a stall

    logic        redirect;
    logic [31:0] target;
    logic        advance;

    logic        ld_valid;
    logic [31:0] ld_instr;

    // A frozen PC means decode is stalled, so its redirect is not yet final.
    assign redirect = PC_WriteEnable & (Branch | Jump);
    assign target   = word_align(Jump ? JumpDest : BranchDest);
    assign advance  = IFIDWriteEnable & PC_WriteEnable;

    assign imem.IMemAddr = fetch_pc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fetch_pc <= word_align(RESET_PC);
            redir_pc <= '0;
            hold_buf <= NOP_INSTR;
        end else begin
            fetch_pc <= fetch_pc_nxt;
            redir_pc <= redir_pc_nxt;
            hold_buf <= hold_buf_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        redir_pc_nxt = redir_pc;
        hold_buf_nxt = hold_buf;
        imem.IMemReq = 1'b0;
        ld_valid     = 1'b0;
        ld_instr     = NOP_INSTR;

        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect) begin
                    fetch_pc_nxt = target;
                end
            end

            FETCH: begin
                imem.IMemReq = 1'b1;
                if (imem.IMemAck) begin
                    if (redirect) begin
                        // No delay slot: the returning word is wrong-path.
                        fetch_pc_nxt = target;
                    end else if (advance) begin
                        ld_valid     = 1'b1;
                        ld_instr     = imem.IMemData;
                        fetch_pc_nxt = fetch_pc + PC_INC;
                    end else begin
                        hold_buf_nxt = imem.IMemData;
                        state_nxt    = HOLD;
                    end
                end else if (redirect) begin
                    // The request cannot be withdrawn; wait out its ack.
                    redir_pc_nxt = target;
                    state_nxt    = SQUASH;
                end
            end

            HOLD: begin
                if (redirect) begin
                    fetch_pc_nxt = target;
                    state_nxt    = FETCH;
                end else if (advance) begin
                    ld_valid     = 1'b1;
                    ld_instr     = hold_buf;
                    fetch_pc_nxt = fetch_pc + PC_INC;
                    state_nxt    = FETCH;
                end
            end

            SQUASH: begin
                imem.IMemReq = 1'b1;
                if (redirect) begin
                    redir_pc_nxt = target;
                end
                if (imem.IMemAck) begin
                    fetch_pc_nxt = redirect ? target : redir_pc;
                    state_nxt    = FETCH;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    ifid_pipe_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk        (Clock),
        .rst_n      (Reset),
        .flush      (IFIDFlush),
        .write_en   (IFIDWriteEnable),
        .load_valid (ld_valid),
        .load_instr (ld_instr),
        .load_pc    (fetch_pc),
        .instr      (Instruction),
        .pc         (PC),
        .valid      (IFIDValid)
    );

`ifdef IF_STAGE_PERF_CNT_EN
    logic fetch_evt;
    logic squash_evt;

    assign fetch_evt  = (state == FETCH) && imem.IMemAck && !redirect;
    assign squash_evt = imem.IMemAck &&
                        (((state == FETCH) && redirect) || (state == SQUASH));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            FetchCount  <= '0;
            SquashCount <= '0;
        end else begin
            if (fetch_evt) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (squash_evt) begin
                SquashCount <= SquashCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A table of per-cycle vectors runs against a zero-wait memory, a few
// hand-written sequences cover multi-cycle latency, squash and reset, and a
// random phase checks the delivered instruction stream against an in-order
// address scoreboard.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch, jump;
    logic [31:0] branch_dest, jump_dest;
    logic        pc_we, ifid_we, ifid_flush;
    logic [31:0] instruction, pc;
    logic        ifid_valid;
`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] fetch_count, squash_count;
`endif

    if_stage_if bus ();

    if_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .Clock           (clk),
        .Reset           (rst_n),
        .Branch          (branch),
        .Jump            (jump),
        .BranchDest      (branch_dest),
        .JumpDest        (jump_dest),
        .PC_WriteEnable  (pc_we),
        .IFIDWriteEnable (ifid_we),
        .IFIDFlush       (ifid_flush),
        .imem            (bus),
        .Instruction     (instruction),
        .PC              (pc),
        .IFIDValid       (ifid_valid)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .FetchCount      (fetch_count),
        .SquashCount     (squash_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Memory model: ack arrives on the (lat+1)-th cycle of each request.
    int   lat = 0;
    int   wait_cnt = 0;
    bit   rand_lat = 0;
    logic req_b, ack_b;

    task automatic tick();
        bus.IMemAck  = rst_n && bus.IMemReq && (wait_cnt >= lat);
        bus.IMemData = bus.IMemReq ? mem_word(bus.IMemAddr) : 32'hDEAD_BEEF;
        req_b = bus.IMemReq;
        ack_b = bus.IMemAck;
        @(posedge clk);
        @(negedge clk);
        if (!rst_n || !req_b || ack_b) wait_cnt = 0;
        else                           wait_cnt++;
        if (ack_b && rand_lat) lat = $urandom_range(0, 3);
    endtask

    task automatic set_in(input logic br, input logic jmp, input logic [31:0] bd,
                          input logic [31:0] jd, input logic pwe, input logic iwe,
                          input logic fl);
        branch = br; jump = jmp; branch_dest = bd; jump_dest = jd;
        pc_we = pwe; ifid_we = iwe; ifid_flush = fl;
    endtask

    task automatic idle_in();
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic check_out(input string tag, input logic exp_req, input logic [31:0] exp_addr,
                             input logic exp_valid, input logic [31:0] exp_pc);
        check({tag, ".req"},   32'(bus.IMemReq), 32'(exp_req));
        check({tag, ".addr"},  bus.IMemAddr, exp_addr);
        check({tag, ".valid"}, 32'(ifid_valid), 32'(exp_valid));
        check({tag, ".instr"}, instruction, exp_valid ? mem_word(exp_pc) : NOP);
        if (exp_valid) check({tag, ".pc"}, pc, exp_pc);
    endtask

    task automatic do_reset(input int l);
        idle_in();
        rst_n = 1'b0;
        lat = l;
        wait_cnt = 0;
        bus.IMemAck = 1'b0;
        bus.IMemData = 32'h0;
        repeat (2) @(negedge clk);
        check("rst.req",   32'(bus.IMemReq), 32'd0);
        check("rst.addr",  bus.IMemAddr, RESET_PC);
        check("rst.valid", 32'(ifid_valid), 32'd0);
        check("rst.instr", instruction, NOP);
        check("rst.pc",    pc, 32'd0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        br;
        logic        jmp;
        logic [31:0] dest;
        logic        pwe;
        logic        iwe;
        logic        fl;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[21];

    initial begin
        logic [31:0] exp_pc, pre_addr, pre_instr, pre_pc, tgt;
        logic        pre_valid, acc;
        int          delivered;

        // in: br jmp dest pwe iwe fl | exp: req addr valid pc
        tbl[0]  = '{0, 0, 32'h000, 1, 1, 0,  0, 32'h00, 0, 32'h00};
        tbl[1]  = '{0, 0, 32'h000, 1, 1, 0,  1, 32'h00, 0, 32'h00};
        tbl[2]  = '{0, 0, 32'h000, 1, 1, 0,  1, 32'h04, 1, 32'h00};
        tbl[3]  = '{0, 0, 32'h000, 1, 1, 0,  1, 32'h08, 1, 32'h04};
        tbl[4]  = '{0, 0, 32'h000, 1, 1, 0,  1, 32'h0C, 1, 32'h08};
        tbl[5]  = '{1, 0, 32'h040, 1, 1, 1,  1, 32'h10, 1, 32'h0C};
        tbl[6]  = '{0, 0, 32'h000, 1, 1, 0,  1, 32'h40, 0, 32'h00};
        tbl[7]  = '{0, 0, 32'h000, 1, 1, 0,  1, 32'h44, 1, 32'h40};
        tbl[8]  = '{0, 0, 32'h000, 1, 1, 0,  1, 32'h48, 1, 32'h44};
        tbl[9]  = '{0, 1, 32'h01E, 1, 1, 1,  1, 32'h4C, 1, 32'h48};
        tbl[10] = '{0, 0, 32'h000, 1, 1, 0,  1, 32'h1C, 0, 32'h00};
        tbl[11] = '{0, 0, 32'h000, 0, 0, 0,  1, 32'h20, 1, 32'h1C};
        tbl[12] = '{0, 0, 32'h000, 0, 0, 0,  0, 32'h20, 1, 32'h1C};
        tbl[13] = '{0, 0, 32'h000, 1, 1, 0,  0, 32'h20, 1, 32'h1C};
        tbl[14] = '{0, 0, 32'h000, 1, 1, 0,  1, 32'h24, 1, 32'h20};
        tbl[15] = '{1, 0, 32'h100, 0, 1, 0,  1, 32'h28, 1, 32'h24};
        tbl[16] = '{0, 0, 32'h000, 1, 1, 0,  0, 32'h28, 0, 32'h00};
        tbl[17] = '{0, 0, 32'h000, 1, 1, 0,  1, 32'h2C, 1, 32'h28};
        tbl[18] = '{0, 0, 32'h000, 1, 0, 1,  1, 32'h30, 1, 32'h2C};
        tbl[19] = '{0, 0, 32'h000, 1, 1, 0,  0, 32'h30, 0, 32'h00};
        tbl[20] = '{0, 0, 32'h000, 1, 1, 0,  1, 32'h34, 1, 32'h30};

        // ---- table: zero-wait memory, redirects, stalls, flush priority ----
        do_reset(0);
        for (int k = 0; k < 21; k++) begin
            check_out($sformatf("row%0d", k), tbl[k].req, tbl[k].addr, tbl[k].valid, tbl[k].pc);
            set_in(tbl[k].br, tbl[k].jmp,
                   tbl[k].br  ? tbl[k].dest : 32'h0000_0500,
                   tbl[k].jmp ? tbl[k].dest : 32'h0000_0300,
                   tbl[k].pwe, tbl[k].iwe, tbl[k].fl);
            tick();
        end

        // ---- three-cycle ack latency: address held, bubbles in between ----
        do_reset(2);
        check_out("lat.c0", 0, 32'h0, 0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_out($sformatf("lat.c%0d", k), 1, 32'h0, 0, 32'h0);
        end
        tick(); check_out("lat.c4", 1, 32'h4, 1, 32'h0);
        tick(); check_out("lat.c5", 1, 32'h4, 0, 32'h0);
        tick(); check_out("lat.c6", 1, 32'h4, 0, 32'h0);
        tick(); check_out("lat.c7", 1, 32'h8, 1, 32'h4);

        // ---- jump + branch during pending request: squash, jump wins ----
        do_reset(2);
        tick(); check_out("sq.c1", 1, 32'h0, 0, 32'h0);
        set_in(1'b1, 1'b1, 32'h40, 32'h80, 1'b1, 1'b1, 1'b1);
        tick(); check_out("sq.c2", 1, 32'h0, 0, 32'h0);
        idle_in();
        tick(); check_out("sq.c3", 1, 32'h0, 0, 32'h0);
        tick(); check_out("sq.c4", 1, 32'h80, 0, 32'h0);
`ifdef IF_STAGE_PERF_CNT_EN
        check("sq.squash_count", squash_count, 32'd1);
        check("sq.fetch_count",  fetch_count,  32'd0);
`endif
        repeat (3) tick();
        check_out("sq.c7", 1, 32'h84, 1, 32'h80);

        // ---- asynchronous reset in the middle of fetching ----
        do_reset(0);
        repeat (4) tick();
        check_out("rm.c4", 1, 32'hC, 1, 32'h8);
        #2 rst_n = 1'b0;
        #1;
        check("rm.req",   32'(bus.IMemReq), 32'd0);
        check("rm.valid", 32'(ifid_valid), 32'd0);
        check("rm.addr",  bus.IMemAddr, RESET_PC);
        check("rm.instr", instruction, NOP);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cnt = 0;
        check_out("rm.c0", 0, RESET_PC, 0, 32'h0);
        tick();
        check_out("rm.c1", 1, RESET_PC, 0, 32'h0);

        // ---- random: in-order delivery scoreboard ----
        do_reset($urandom_range(0, 3));
        rand_lat  = 1;
        exp_pc    = RESET_PC;
        delivered = 0;
        for (int n = 0; n < 3000; n++) begin
            branch      = ($urandom % 8) == 0;
            jump        = ($urandom % 12) == 0;
            branch_dest = $urandom;
            jump_dest   = $urandom;
            pc_we       = ($urandom % 5) != 0;
            ifid_we     = ($urandom % 5) != 0;
            acc         = pc_we && (branch || jump);
            ifid_flush  = acc && (($urandom % 4) != 0);
            tgt         = (jump ? jump_dest : branch_dest) & 32'hFFFF_FFFC;
            pre_addr    = bus.IMemAddr;
            pre_instr   = instruction;
            pre_pc      = pc;
            pre_valid   = ifid_valid;
            tick();
            if (req_b && !ack_b) begin
                check("rnd.req_held",  32'(bus.IMemReq), 32'd1);
                check("rnd.addr_held", bus.IMemAddr, pre_addr);
            end
            check("rnd.addr_align", bus.IMemAddr & 32'h3, 32'h0);
            if (ifid_flush) begin
                check("rnd.flush_valid", 32'(ifid_valid), 32'd0);
                check("rnd.flush_instr", instruction, NOP);
            end else if (!ifid_we) begin
                check("rnd.hold_valid", 32'(ifid_valid), 32'(pre_valid));
                check("rnd.hold_instr", instruction, pre_instr);
                check("rnd.hold_pc",    pc, pre_pc);
            end else if (acc) begin
                check("rnd.redir_bubble", 32'(ifid_valid), 32'd0);
            end else if (ifid_valid) begin
                check("rnd.pc",    pc, exp_pc);
                check("rnd.instr", instruction, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                check("rnd.bubble_instr", instruction, NOP);
            end
            if (acc) exp_pc = tgt;
        end
        rand_lat = 0;
        check("rnd.progress", 32'(delivered > 300), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage and the producer side of the IF/ID interface that the decode stage consumes.
- Owns the fetch PC and issues single-outstanding requests to instruction memory over a req/ack handshake with variable latency.
- Applies redirects (Branch/Jump), stalls and flushes returned by decode/hazard logic.
- Drives the IF/ID pipeline register: Instruction and PC.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0000, bubble encoding loaded into IF/ID on flush or empty fetch

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
Branch  input  1  taken-branch redirect from decode
Jump  input  1  jump redirect from decode
BranchDest  input  32  branch target
JumpDest  input  32  jump target
PC_WriteEnable  input  1  0 = freeze fetch PC (load-use stall)
IFIDWriteEnable  input  1  0 = hold IF/ID contents
IFIDFlush  input  1  load bubble into IF/ID
IMemReq  output  1  fetch request valid
IMemAddr  output  32  fetch address, word aligned
IMemAck  input  1  data valid; may assert same cycle as IMemReq
IMemData  input  32  fetched instruction
Instruction  output  32  IF/ID instruction to decode
PC  output  32  IF/ID address of Instruction
IFIDValid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE, FetchPC=RESET_PC, IMemReq=0, IMemAddr=RESET_PC.
  - Instruction=NOP_INSTR, PC=0, IFIDValid=0, squash flag=0.
  - An in-flight request is abandoned; memory must tolerate this.
- Request rules:
  - IMemAddr = FetchPC, held stable while IMemReq=1 until the IMemAck cycle.
  - At most one outstanding request.
  - Addresses always have bits[1:0]=0; redirect targets are masked.
- Redirect:
  - Target = JumpDest if Jump=1, else BranchDest if Branch=1 (Jump has priority).
  - Accepted only when PC_WriteEnable=1; ignored otherwise.
  - There is no delay slot: the instruction being fetched is wrong-path.
- IF/ID register:
  - IFIDFlush=1 loads NOP_INSTR, IFIDValid=0. Flush has priority over IFIDWriteEnable=0.
  - Otherwise IFIDWriteEnable=0 holds the register.
  - Otherwise it loads the delivered instruction (IFIDValid=1) or a bubble (IFIDValid=0).
- States:
  - IDLE: IMemReq=0; next cycle -> FETCH.
  - FETCH: IMemReq=1.
    - Ack and redirect: discard data; FetchPC<=target; stay FETCH.
    - Ack, no redirect, IFIDWriteEnable=1, PC_WriteEnable=1: IF/ID<=IMemData/FetchPC; FetchPC<=FetchPC+4 (32-bit wrap); stay FETCH.
    - Ack, no redirect, IFIDWriteEnable=0 or PC_WriteEnable=0: capture into holding buffer; -> HOLD.
    - No ack and redirect: RedirPC<=target; -> SQUASH.
    - No ack, no redirect: IF/ID gets bubble when writable.
  - HOLD: IMemReq=0.
    - Redirect: drop buffer; FetchPC<=target; -> FETCH.
    - IFIDWriteEnable=1 and PC_WriteEnable=1: IF/ID<=buffer; FetchPC<=FetchPC+4; -> FETCH.
  - SQUASH: IMemReq=1 with the old address still held.
    - Further redirect: RedirPC updated (latest wins).
    - On ack: discard data; FetchPC<=RedirPC (or the newer same-cycle target); -> FETCH.
    - IF/ID receives bubbles throughout.
- Latency and throughput:
  - Zero-wait memory (ack same cycle): 1 instruction/cycle; instruction at address A appears on Instruction one cycle after its ack.
  - First valid IF/ID at cycle 2 after reset release with zero-wait memory.

Optional Feature:
IF_STAGE_PERF_CNT_EN
- Defined: adds outputs FetchCount[31:0] and SquashCount[31:0].
  - FetchCount increments on each ack delivered to IF/ID or the holding buffer.
  - SquashCount increments on each discarded ack.
  - Both reset to 0 and wrap.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package if_pkg:
  - fetch state typedef (IDLE, FETCH, HOLD, SQUASH).
  - NOP constant.
  - PC_INC=4.
  - word-align mask.
- One sub-module, ifid_pipe_reg: the IF/ID register with flush/write-enable priority and the valid bit.

Test Plan:
- Zero-wait memory, no stalls, reset release -> IMemAddr 0,4,8,12 on consecutive cycles; Instruction follows one cycle later, IFIDValid=1 continuously.
- Ack latency 3 cycles -> IMemAddr held stable for 3 cycles; IF/ID bubbles (IFIDValid=0) between valid instructions.
- Branch=1, BranchDest=0x40, coincident with ack of 0x10 -> data discarded; next IMemAddr=0x40; IF/ID flushed to NOP.
- Jump=1 (JumpDest=0x80) and Branch=1 (0x40) during a pending request, ack 2 cycles later -> SQUASH; stale data dropped; next IMemAddr=0x80.
- IFIDWriteEnable=0 and PC_WriteEnable=0 for 2 cycles at ack of 0x20 -> HOLD, IMemReq=0; on release Instruction=data@0x20, then IMemAddr=0x24.
- Reset asserted mid-FETCH -> IMemReq drops immediately; IFIDValid=0; after release IMemAddr=RESET_PC.
